// File: rtl/comparator_seq_nbit.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle.
// Signed compares use offset-binary so every chunk compare is unsigned.
module comparator_seq_nbit #(
    parameter int WIDTH      = 8,
    parameter int CHUNK      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] msb_mask;
    logic [IW-1:0]    idx;
    logic             found;
    logic             rec_gt;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             accept;
    logic             diff;
    logic             last;
    logic             finish;
    logic             res_gt;
    logic             res_lt;

    // Flipping both MSBs maps two's complement order onto unsigned order.
    assign msb_mask = {signed_mode, {(WIDTH-1){1'b0}}};

    // Current chunk always sits at the top of the shift registers.
    assign ca     = a_sh[WIDTH-1 -: CHUNK];
    assign cb     = b_sh[WIDTH-1 -: CHUNK];
    assign diff   = (ca != cb);
    assign last   = (idx == IW'(N - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign finish = (state == RUN) &&
                    (last || ((EARLY_EXIT != 0) && diff && !found));

    // An already recorded direction wins over the current chunk.
    assign res_gt = found ? rec_gt  : (diff && (ca > cb));
    assign res_lt = found ? !rec_gt : (diff && (ca < cb));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; DONE always leaves after one cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (finish) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, chunk walk and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            idx    <= '0;
            found  <= 1'b0;
            rec_gt <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
        end else if (accept) begin
            a_sh   <= a ^ msb_mask;
            b_sh   <= b ^ msb_mask;
            idx    <= '0;
            found  <= 1'b0;
            rec_gt <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
        end else if (state == RUN) begin
            a_sh <= a_sh << CHUNK;
            b_sh <= b_sh << CHUNK;
            idx  <= idx + IW'(1);
            if (!found && diff) begin
                found  <= 1'b1;
                rec_gt <= (ca > cb);
            end
            if (finish) begin
                gt <= res_gt;
                lt <= res_lt;
                eq <= !res_gt && !res_lt;
            end
        end
    end

endmodule
